// File: rtl/noc_output_stage_seq.sv
// noc_output_stage_seq: tile sequencer for the residual+LayerNorm output stages.
// A job of TOKENS rows is split into N1-row tiles; one command per tile goes to the
// NoC compute engine with at most MAX_OUT in flight, and the job ends in DONE or ERR.
// Mode 0 runs the self-output stage (K=EMBED), mode 1 the FFN-output stage (K=FFN).
module noc_output_stage_seq #(
  parameter int TOKENS    = 128,
  parameter int EMBED     = 768,
  parameter int FFN       = 3072,
  parameter int N1        = 16,
  parameter int D_W       = 8,
  parameter int ADDR_W    = 64,
  parameter int MAX_OUT   = 4,
  parameter int TIMEOUT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] addr_weight,
  input  logic [ADDR_W-1:0] addr_res,
  input  logic [ADDR_W-1:0] addr_out,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_src,
  output logic [ADDR_W-1:0] cmd_wgt,
  output logic [ADDR_W-1:0] cmd_res,
  output logic [ADDR_W-1:0] cmd_dst,
  output logic [15:0]       cmd_k,
  input  logic              cmp_valid,
  input  logic              cmp_err,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int NT     = TOKENS / N1;
  localparam int TILE_W = $clog2(NT + 1);
  localparam int BYTES  = D_W / 8;

  // Per-tile address strides; the input stride depends on K, the row stride does not.
  localparam logic [ADDR_W-1:0]    STEP_SRC_E = ADDR_W'(N1 * EMBED * BYTES);
  localparam logic [ADDR_W-1:0]    STEP_SRC_F = ADDR_W'(N1 * FFN * BYTES);
  localparam logic [ADDR_W-1:0]    STEP_ROW   = ADDR_W'(N1 * EMBED * BYTES);
  localparam logic [TILE_W-1:0]    LAST_TILE  = TILE_W'(NT - 1);
  localparam logic [3:0]           MAX_OUT_C  = 4'(MAX_OUT);
  localparam logic [15:0]          K_EMBED    = 16'(EMBED);
  localparam logic [15:0]          K_FFN      = 16'(FFN);
  // The watchdog fires on the increment that would make it all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_PRE     = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q;
  logic [ADDR_W-1:0]   srcAddr_q, wgtAddr_q, resAddr_q, dstAddr_q;
  logic [15:0]         kDim_q;
  logic [TILE_W-1:0]   tile_q;
  logic [3:0]          out_q, out_d;
  logic [TIMEOUT_W-1:0] wdog_q;
  logic [1:0]          code_q;

  logic                active, accept, handshake, cmpSeen, lastIssue;
  logic                engErr, spurErr, toErr, abortErr, anyErr;
  logic [1:0]          errCode;

  assign active    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign accept    = start && !active;
  assign handshake = cmd_valid && cmd_ready;
  assign cmpSeen   = cmp_valid && active;
  assign lastIssue = handshake && (tile_q == LAST_TILE);

  // Classify this cycle's error sources and pick the winning code by priority.
  always_comb begin
    engErr   = cmpSeen && cmp_err;
    spurErr  = cmpSeen && (out_q == 4'd0) && !handshake;
    toErr    = active && (out_q != 4'd0) && !cmp_valid && (wdog_q == WD_PRE);
    abortErr = active && abort;
    anyErr   = engErr || spurErr || toErr || abortErr;
    if (engErr)       errCode = 2'd1;
    else if (spurErr) errCode = 2'd3;
    else if (toErr)   errCode = 2'd2;
    else              errCode = 2'd3;
  end

  // Outstanding count: a handshake and a completion in the same cycle cancel out.
  always_comb begin
    out_d = out_q;
    if (handshake && !cmpSeen)
      out_d = out_q + 4'd1;
    else if (!handshake && cmpSeen && (out_q != 4'd0))
      out_d = out_q - 4'd1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: issue all tiles, drain completions, any error parks in ERR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (accept) state_d = S_ISSUE;
      S_ISSUE: begin
        if (anyErr)         state_d = S_ERR;
        else if (lastIssue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (anyErr)              state_d = S_ERR;
        else if (out_d == 4'd0)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state and the held command fields.
  always_comb begin
    cmd_valid = (state_q == S_ISSUE) && (out_q < MAX_OUT_C);
    busy      = active;
    done      = (state_q == S_DONE);
    error     = (state_q == S_ERR);
    err_code  = code_q;
    cmd_src   = srcAddr_q;
    cmd_wgt   = wgtAddr_q;
    cmd_res   = resAddr_q;
    cmd_dst   = dstAddr_q;
    cmd_k     = kDim_q;
  end

  // Job datapath: latch on start, step addresses per handshake, track outstanding and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      srcAddr_q <= '0;
      wgtAddr_q <= '0;
      resAddr_q <= '0;
      dstAddr_q <= '0;
      kDim_q    <= '0;
      tile_q    <= '0;
      out_q     <= '0;
      wdog_q    <= '0;
      code_q    <= '0;
    end else if (accept) begin
      mode_q    <= mode;
      srcAddr_q <= addr_in;
      wgtAddr_q <= addr_weight;
      resAddr_q <= addr_res;
      dstAddr_q <= addr_out;
      kDim_q    <= mode ? K_FFN : K_EMBED;
      tile_q    <= '0;
      out_q     <= '0;
      wdog_q    <= '0;
      code_q    <= '0;
    end else if (active) begin
      if (handshake) begin
        tile_q    <= tile_q + TILE_W'(1);
        srcAddr_q <= srcAddr_q + (mode_q ? STEP_SRC_F : STEP_SRC_E);
        resAddr_q <= resAddr_q + STEP_ROW;
        dstAddr_q <= dstAddr_q + STEP_ROW;
      end
      out_q <= out_d;
      if (cmp_valid)
        wdog_q <= '0;
      else if (out_q != 4'd0)
        wdog_q <= wdog_q + TIMEOUT_W'(1);
      if (anyErr)
        code_q <= errCode;
    end
  end

endmodule

// File: tb/tb_noc_output_stage_seq.sv
// tb_noc_output_stage_seq: scoreboard bench for the output-stage tile sequencer.
// Expected tile commands are queued when a job is launched and popped on every
// handshake; an engine model returns completions a fixed delay after each command.
module tb_noc_output_stage_seq;

  localparam int ADDR_W = 64;
  localparam int NT     = 8;
  localparam int N1     = 16;
  localparam int EMBED  = 768;
  localparam int FFN    = 3072;

  typedef struct {
    logic [63:0] src;
    logic [63:0] wgt;
    logic [63:0] res;
    logic [63:0] dst;
    logic [15:0] k;
  } cmd_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [ADDR_W-1:0] addrIn = '0, addrWeight = '0, addrRes = '0, addrOut = '0;
  logic              cmdValid, cmdReady = 1'b0;
  logic [ADDR_W-1:0] cmdSrc, cmdWgt, cmdRes, cmdDst;
  logic [15:0]       cmdK;
  logic              cmpValid = 1'b0, cmpErr = 1'b0;
  logic              busy, done, error;
  logic [1:0]        errCode;

  // Second instance with a short watchdog, driven independently.
  logic              t2Start = 1'b0, t2CmdReady = 1'b1, t2CmpValid = 1'b0;
  logic              t2CmdValid, t2Busy, t2Done, t2Error;
  logic [ADDR_W-1:0] t2Src, t2Wgt, t2Res, t2Dst;
  logic [15:0]       t2K;
  logic [1:0]        t2ErrCode;

  int   checks = 0;
  int   failures = 0;
  cmd_t sb[$];
  int   compDue[$];
  int   cyc = 0;
  int   issued = 0;
  int   cmpCount = 0;
  int   errAt = 0;
  int   manualReq = 0;
  bit   engineOn = 1'b0;
  bit   autoComp = 1'b0;

  noc_output_stage_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .addr_in(addrIn), .addr_weight(addrWeight), .addr_res(addrRes), .addr_out(addrOut),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .cmd_src(cmdSrc), .cmd_wgt(cmdWgt), .cmd_res(cmdRes), .cmd_dst(cmdDst), .cmd_k(cmdK),
    .cmp_valid(cmpValid), .cmp_err(cmpErr),
    .busy(busy), .done(done), .error(error), .err_code(errCode)
  );

  noc_output_stage_seq #(.TIMEOUT_W(4)) dutTo (
    .clk(clk), .rst(rst), .start(t2Start), .mode(1'b0), .abort(1'b0),
    .addr_in(64'h100), .addr_weight(64'h200), .addr_res(64'h300), .addr_out(64'h400),
    .cmd_valid(t2CmdValid), .cmd_ready(t2CmdReady),
    .cmd_src(t2Src), .cmd_wgt(t2Wgt), .cmd_res(t2Res), .cmd_dst(t2Dst), .cmd_k(t2K),
    .cmp_valid(t2CmpValid), .cmp_err(1'b0),
    .busy(t2Busy), .done(t2Done), .error(t2Error), .err_code(t2ErrCode)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Launches a job and queues the commands it must produce (addresses from a direct product).
  task automatic applyStimulus(input logic m, input logic [63:0] ain, input logic [63:0] aw,
                               input logic [63:0] ar, input logic [63:0] ao);
    cmd_t c;
    int   k;
    k = m ? FFN : EMBED;
    sb.delete();
    for (int t = 0; t < NT; t++) begin
      c.src = ain + 64'(t * N1 * k);
      c.wgt = aw;
      c.res = ar + 64'(t * N1 * EMBED);
      c.dst = ao + 64'(t * N1 * EMBED);
      c.k   = 16'(k);
      sb.push_back(c);
    end
    issued = 0;
    cmpCount = 0;
    mode = m; addrIn = ain; addrWeight = aw; addrRes = ar; addrOut = ao;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for the job to end in DONE or ERR within a cycle budget.
  task automatic waitJobEnd(input int budget);
    bit ended;
    ended = 1'b0;
    for (int i = 0; i < budget && !ended; i++) begin
      @(negedge clk);
      if (done || error) ended = 1'b1;
    end
    if (!ended) checkOutput("job_end_timeout", 64'(busy), 64'(0));
  endtask

  // Lets late completions drain before the next job.
  task automatic settle();
    repeat (15) @(negedge clk);
  endtask

  // Engine model and scoreboard: sample just after the falling edge, compare handshakes,
  // and return completions ten cycles after each accepted command.
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (cmdValid && cmdReady) begin
        issued++;
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_cmd", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          checkOutput("cmd_src", cmdSrc, e.src);
          checkOutput("cmd_wgt", cmdWgt, e.wgt);
          checkOutput("cmd_res", cmdRes, e.res);
          checkOutput("cmd_dst", cmdDst, e.dst);
          checkOutput("cmd_k", 64'(cmdK), 64'(e.k));
        end
        if (engineOn && autoComp) compDue.push_back(cyc + 10);
      end
      if (engineOn) begin
        cmpValid = 1'b0;
        cmpErr   = 1'b0;
        if (compDue.size() > 0 && compDue[0] <= cyc) begin
          void'(compDue.pop_front());
          cmpValid = 1'b1;
          cmpCount++;
          if (cmpCount == errAt) cmpErr = 1'b1;
        end else if (manualReq > 0) begin
          manualReq--;
          cmpValid = 1'b1;
        end
      end
    end
  end

  // Main sequence of directed scenarios.
  initial begin
    int snap;

    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_error", 64'(error), 64'(0));
    checkOutput("rst_cmd_valid", 64'(cmdValid), 64'(0));
    checkOutput("rst_err_code", 64'(errCode), 64'(0));
    checkOutput("rst_cmd_src", cmdSrc, 64'(0));
    checkOutput("rst_cmd_k", 64'(cmdK), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Mode 0 full job with a well-behaved engine.
    engineOn = 1'b1; autoComp = 1'b1; cmdReady = 1'b1; errAt = 0;
    applyStimulus(1'b0, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h4000_0000);
    checkOutput("m0_first_cmd_latency", 64'(cmdValid), 64'(1));
    checkOutput("m0_busy", 64'(busy), 64'(1));
    waitJobEnd(500);
    checkOutput("m0_done", 64'(done), 64'(1));
    checkOutput("m0_error", 64'(error), 64'(0));
    checkOutput("m0_issued", 64'(issued), 64'(NT));
    checkOutput("m0_sb_empty", 64'(sb.size()), 64'(0));
    repeat (3) @(negedge clk);
    checkOutput("m0_done_held", 64'(done), 64'(1));
    checkOutput("m0_busy_low", 64'(busy), 64'(0));
    settle();

    // Mode 1 full job.
    applyStimulus(1'b1, 64'h0000_0001_0000_0000, 64'hABCD_0000, 64'h5000_0000, 64'h6000_0000);
    waitJobEnd(500);
    checkOutput("m1_done", 64'(done), 64'(1));
    checkOutput("m1_issued", 64'(issued), 64'(NT));
    checkOutput("m1_k", 64'(cmdK), 64'(FFN));
    settle();

    // Engine withholds completions: outstanding limit, one completion frees one slot.
    autoComp = 1'b0;
    applyStimulus(1'b0, 64'h10, 64'h20, 64'h30, 64'h40);
    repeat (20) @(negedge clk);
    checkOutput("wh_issued_max", 64'(issued), 64'(4));
    checkOutput("wh_cmd_valid_low", 64'(cmdValid), 64'(0));
    mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("wh_start_ignored_k", 64'(cmdK), 64'(EMBED));
    checkOutput("wh_start_ignored_busy", 64'(busy), 64'(1));
    manualReq = 1;
    repeat (10) @(negedge clk);
    checkOutput("wh_one_more", 64'(issued), 64'(5));
    checkOutput("wh_error_none", 64'(error), 64'(0));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_error", 64'(error), 64'(1));
    checkOutput("abort_code", 64'(errCode), 64'(3));
    checkOutput("abort_done_low", 64'(done), 64'(0));
    settle();

    // Engine error on the third completion stops issue; a new start recovers.
    autoComp = 1'b1; errAt = 3;
    applyStimulus(1'b0, 64'h1000, 64'h2000, 64'h3000, 64'h4000);
    waitJobEnd(500);
    checkOutput("eng_error", 64'(error), 64'(1));
    checkOutput("eng_code", 64'(errCode), 64'(1));
    checkOutput("eng_done_low", 64'(done), 64'(0));
    snap = issued;
    repeat (20) @(negedge clk);
    checkOutput("eng_no_more_cmds", 64'(issued), 64'(snap));
    checkOutput("eng_code_kept", 64'(errCode), 64'(1));
    errAt = 0;
    settle();
    applyStimulus(1'b0, 64'h1000, 64'h2000, 64'h3000, 64'h4000);
    checkOutput("rerun_code_cleared", 64'(errCode), 64'(0));
    waitJobEnd(500);
    checkOutput("rerun_done", 64'(done), 64'(1));
    checkOutput("rerun_error", 64'(error), 64'(0));
    checkOutput("rerun_issued", 64'(issued), 64'(NT));
    settle();

    // Completion with nothing outstanding is spurious.
    engineOn = 1'b0; autoComp = 1'b0; cmpValid = 1'b0; cmpErr = 1'b0; cmdReady = 1'b0;
    applyStimulus(1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    cmpValid = 1'b1;
    @(negedge clk);
    cmpValid = 1'b0;
    checkOutput("spur_error", 64'(error), 64'(1));
    checkOutput("spur_code", 64'(errCode), 64'(3));
    checkOutput("spur_issued", 64'(issued), 64'(0));
    settle();

    // Handshake and completion in one cycle leave the count at one.
    applyStimulus(1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    cmdReady = 1'b1;
    @(negedge clk);
    cmpValid = 1'b1;
    @(negedge clk);
    cmdReady = 1'b0;
    cmpValid = 1'b0;
    checkOutput("same_cycle_no_error", 64'(error), 64'(0));
    checkOutput("same_cycle_busy", 64'(busy), 64'(1));
    cmpValid = 1'b1;
    @(negedge clk);
    cmpValid = 1'b0;
    checkOutput("same_cycle_count_one", 64'(error), 64'(0));
    cmpValid = 1'b1;
    @(negedge clk);
    cmpValid = 1'b0;
    checkOutput("same_cycle_then_spur", 64'(errCode), 64'(3));
    checkOutput("same_cycle_issued", 64'(issued), 64'(2));
    settle();

    // Watchdog with a 4-bit counter and no completions.
    t2Start = 1'b1;
    @(negedge clk);
    t2Start = 1'b0;
    checkOutput("to_cmd_valid", 64'(t2CmdValid), 64'(1));
    @(negedge clk);
    repeat (14) @(negedge clk);
    checkOutput("to_not_yet", 64'(t2Error), 64'(0));
    @(negedge clk);
    checkOutput("to_error", 64'(t2Error), 64'(1));
    checkOutput("to_code", 64'(t2ErrCode), 64'(2));

    // Reset in the middle of a job clears everything immediately.
    engineOn = 1'b1; autoComp = 1'b1; cmdReady = 1'b1;
    applyStimulus(1'b1, 64'h7000, 64'h8000, 64'h9000, 64'hA000);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_cmd_valid", 64'(cmdValid), 64'(0));
    checkOutput("midrst_cmd_src", cmdSrc, 64'(0));
    checkOutput("midrst_cmd_k", 64'(cmdK), 64'(0));
    checkOutput("midrst_done_error", 64'({done, error, errCode}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    settle();
    checkOutput("post_rst_idle", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
